// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - two-master round-robin Wishbone arbiter with ACK watchdog
module wb_arbiter #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [XLEN-1:0]   i_m0_adr,
   input  logic [XLEN-1:0]   i_m0_dat_w,
   input  logic [XLEN/8-1:0] i_m0_sel,
   input  logic              i_m0_we,
   input  logic              i_m0_stb,
   input  logic              i_m0_cyc,
   output logic [XLEN-1:0]   o_m0_dat_r,
   output logic              o_m0_ack,
   input  logic [XLEN-1:0]   i_m1_adr,
   input  logic [XLEN-1:0]   i_m1_dat_w,
   input  logic [XLEN/8-1:0] i_m1_sel,
   input  logic              i_m1_we,
   input  logic              i_m1_stb,
   input  logic              i_m1_cyc,
   output logic [XLEN-1:0]   o_m1_dat_r,
   output logic              o_m1_ack,
   output logic [XLEN-1:0]   o_s_adr,
   output logic [XLEN-1:0]   o_s_dat_w,
   output logic [XLEN/8-1:0] o_s_sel,
   output logic              o_s_we,
   output logic              o_s_stb,
   output logic              o_s_cyc,
   input  logic [XLEN-1:0]   i_s_dat_r,
   input  logic              i_s_ack,
   output logic [1:0]        grant,
   output logic              bus_fault
);

   localparam int WDW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WDW-1:0] WD_MAX = WDW'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

   state_t         r_state;
   logic           r_last;
   logic [WDW-1:0] r_wd;
   logic           r_fault;
   logic [1:0]     r_grant;

   logic              w_granted;
   logic              w_sel_m1;
   logic [XLEN-1:0]   w_m_adr;
   logic [XLEN-1:0]   w_m_dat_w;
   logic [XLEN/8-1:0] w_m_sel;
   logic              w_m_we;
   logic              w_m_stb;
   logic              w_m_cyc;
   logic              w_timeout;
   logic              w_ack;
   logic [XLEN-1:0]   w_dat_r;

   assign w_granted = (r_state != IDLE);
   assign w_sel_m1  = (r_state == GNT1);
   assign w_m_adr   = w_sel_m1 ? i_m1_adr   : i_m0_adr;
   assign w_m_dat_w = w_sel_m1 ? i_m1_dat_w : i_m0_dat_w;
   assign w_m_sel   = w_sel_m1 ? i_m1_sel   : i_m0_sel;
   assign w_m_we    = w_sel_m1 ? i_m1_we    : i_m0_we;
   assign w_m_stb   = w_sel_m1 ? i_m1_stb   : i_m0_stb;
   assign w_m_cyc   = w_sel_m1 ? i_m1_cyc   : i_m0_cyc;

   // A real ACK in the final watchdog cycle beats the synthetic one.
   assign w_timeout = w_granted && w_m_stb && !i_s_ack && (r_wd == WD_MAX);
   assign w_ack     = i_s_ack || w_timeout;
   assign w_dat_r   = w_timeout ? '0 : i_s_dat_r;

   always_comb begin
      o_s_adr    = '0;
      o_s_dat_w  = '0;
      o_s_sel    = '0;
      o_s_we     = 1'b0;
      o_s_stb    = 1'b0;
      o_s_cyc    = 1'b0;
      o_m0_ack   = 1'b0;
      o_m0_dat_r = '0;
      o_m1_ack   = 1'b0;
      o_m1_dat_r = '0;
      if (w_granted) begin
         o_s_adr   = w_m_adr;
         o_s_dat_w = w_m_dat_w;
         o_s_sel   = w_m_sel;
         o_s_we    = w_m_we;
         o_s_stb   = w_m_stb && !w_timeout;
         o_s_cyc   = w_m_cyc && !w_timeout;
         if (w_sel_m1) begin
            o_m1_ack   = w_ack;
            o_m1_dat_r = w_dat_r;
         end else begin
            o_m0_ack   = w_ack;
            o_m0_dat_r = w_dat_r;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
         r_wd    <= '0;
         r_fault <= 1'b0;
         r_grant <= 2'b00;
      end else begin
         case (r_state)
            IDLE: begin
               r_wd <= '0;
               // On a tie, the master that was not served last wins.
               if (i_m0_cyc && (!i_m1_cyc || r_last)) begin
                  r_state <= GNT0;
                  r_last  <= 1'b0;
                  r_grant <= 2'b01;
               end else if (i_m1_cyc) begin
                  r_state <= GNT1;
                  r_last  <= 1'b1;
                  r_grant <= 2'b10;
               end
            end
            GNT0, GNT1: begin
               if (!w_m_cyc || w_timeout) begin
                  r_state <= IDLE;
                  r_grant <= 2'b00;
                  r_wd    <= '0;
                  if (w_timeout) r_fault <= 1'b1;
               end else if (w_m_stb && !i_s_ack) begin
                  r_wd <= r_wd + WDW'(1);
               end else begin
                  r_wd <= '0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_grant <= 2'b00;
               r_wd    <= '0;
            end
         endcase
      end
   end

   assign grant     = r_grant;
   assign bus_fault = r_fault;

endmodule
